add_err_monitor: RTL and testbench

//  Downstream characterisation stage for the 12-bit approximate adders (add12u_*). Takes each

---
 rtl/add_err_pkg.sv | 28 ++
 rtl/add_err_calc.sv | 26 ++
 rtl/add_err_monitor.sv | 124 ++++++++++++
 tb/tb_add_err_monitor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_err_pkg.sv
// add_err_pkg: shared widths, FSM state encoding and the S1 pipeline record
// for the approximate-adder error monitor.
//   W      operand width (approximate sum is W+1 bits)
//   CNT_W  sample / error counter width
//   SAE_W  sum-of-absolute-error width, wide enough that a full run of
//          worst-case errors cannot overflow it
package add_err_pkg;

  localparam int W     = 12;
  localparam int CNT_W = 24;
  localparam int SAE_W = W + 1 + CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One accepted sample after the first pipeline stage.
  typedef struct packed {
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   e;
  } s1_t;

endpackage

// File: rtl/add_err_calc.sv
// add_err_calc: combinational exact sum and absolute error of an approximate
// adder result.
//   a, b     operands (WIDTH bits)
//   o        approximate sum under test (WIDTH+1 bits)
//   abs_err  |(a+b) - o|, computed by compare-then-subtract so it never wraps
module add_err_calc #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   o,
  output logic [WIDTH:0]   abs_err
);

  logic [WIDTH:0] exact;

  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    if (exact >= o) begin
      abs_err = exact - o;
    end else begin
      abs_err = o - exact;
    end
  end

endmodule

// File: rtl/add_err_monitor.sv
// add_err_monitor: accumulates error statistics of an approximate adder over
// a programmed run of n_samples operand/result triples.
//   clk, rst_n        clock, synchronous active-low reset
//   start, n_samples  begin a run (accepted only in IDLE/DONE), run length
//   in_valid/in_ready input handshake; in_a, in_b, in_o the triple
//   busy, done        run in progress / statistics final
//   sample_cnt, err_cnt, sae, wce, wce_a, wce_b  accumulated statistics
//   state_dbg         current FSM state
//
// Handshake: a triple is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready does not depend on in_valid; in_valid while
// in_ready is low has no effect.
module add_err_monitor
  import add_err_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SAE_W-1:0] sae,
  output logic [W:0]       wce,
  output logic [W-1:0]     wce_a,
  output logic [W-1:0]     wce_b,
  output state_t           state_dbg
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] acc;
  s1_t              s1;
  logic [W:0]       calc_e;
  logic             accept;
  logic             start_run;

  add_err_calc #(.WIDTH(W)) u_calc (
    .a       (in_a),
    .b       (in_b),
    .o       (in_o),
    .abs_err (calc_e)
  );

  assign in_ready  = (state == RUN) && (acc < n_lat);
  assign accept    = in_valid && in_ready;
  assign start_run = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = RUN;
      // Leave RUN the cycle after the last accept (immediately if n is 0).
      RUN:        if (acc >= n_lat) next_state = DRAIN;
      // The last sample is in S1 at most; once S1 is empty, S2 has absorbed it.
      DRAIN:      if (!s1.valid) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_lat      <= '0;
      acc        <= '0;
      s1         <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sae        <= '0;
      wce        <= '0;
      wce_a      <= '0;
      wce_b      <= '0;
    end else if (start_run) begin
      n_lat      <= n_samples;
      acc        <= '0;
      s1         <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sae        <= '0;
      wce        <= '0;
      wce_a      <= '0;
      wce_b      <= '0;
    end else begin
      // S1: capture the accepted triple's operands and absolute error.
      s1.valid <= accept;
      s1.a     <= in_a;
      s1.b     <= in_b;
      s1.e     <= calc_e;
      if (accept) begin
        acc <= acc + CNT_W'(1);
      end
      // S2: fold one sample into the statistics.
      if (s1.valid) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_cnt    <= err_cnt + CNT_W'(s1.e != '0);
        sae        <= sae + SAE_W'(s1.e);
        // Strict compare: an equal later error keeps the earlier operands.
        if (s1.e > wce) begin
          wce   <= s1.e;
          wce_a <= s1.a;
          wce_b <= s1.b;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_err_monitor.sv
module tb_add_err_monitor;
  import add_err_pkg::*;

  // clock / reset
  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W:0]       in_o;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [SAE_W-1:0] sae;
  logic [W:0]       wce;
  logic [W-1:0]     wce_a;
  logic [W-1:0]     wce_b;
  state_t           state_dbg;

  always #5 clk = ~clk;

  add_err_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_samples  (n_samples),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_o       (in_o),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .sae        (sae),
    .wce        (wce),
    .wce_a      (wce_a),
    .wce_b      (wce_b),
    .state_dbg  (state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W:0]   exp_e_q[$];
  int           acc_cyc_q[$];
  // directed triples, consumed on accept before random ones are used
  int d_a[$];
  int d_b[$];
  int d_o[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference statistics from the list of accepted samples, straight from the
  // definitions: count, nonzero count, sum, first strict maximum.
  task automatic check_stats(input string tag);
    longint sum_e = 0;
    int     n_err = 0;
    int     max_e = 0;
    int     max_a = 0;
    int     max_b = 0;
    foreach (exp_e_q[i]) begin
      sum_e += longint'(exp_e_q[i]);
      if (exp_e_q[i] != 0) n_err++;
      if (int'(exp_e_q[i]) > max_e) begin
        max_e = int'(exp_e_q[i]);
        max_a = int'(exp_a_q[i]);
        max_b = int'(exp_b_q[i]);
      end
    end
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(exp_e_q.size()));
    check({tag, "_err_cnt"},    64'(err_cnt),    64'(n_err));
    check({tag, "_sae"},        64'(sae),        64'(sum_e));
    check({tag, "_wce"},        64'(wce),        64'(max_e));
    check({tag, "_wce_a"},      64'(wce_a),      64'(max_a));
    check({tag, "_wce_b"},      64'(wce_b),      64'(max_b));
  endtask

  function automatic int abs_err(input int a, input int b, input int o);
    int s;
    s = a + b;
    return (s > o) ? s - o : o - s;
  endfunction

  function automatic int rand_o(input int a, input int b);
    int s;
    int r;
    s = a + b;
    r = int'($urandom_range(0, 3));
    case (r)
      0: return s;
      1: return (s + int'($urandom_range(0, 15)) > 8191) ? 8191 : s + int'($urandom_range(0, 15));
      2: return (s < 16) ? 0 : s - int'($urandom_range(0, 15));
      default: return int'($urandom_range(0, 8191));
    endcase
  endfunction

  // driver: one full run; returns cycles waited for done after stimulus ends
  task automatic run_test(input string tag, input int n, input int valid_pct,
                          input int min_cycles, input int restart_at, output int wait_cyc);
    int model_acc;
    int cyc;
    int lo;
    int hi;
    int a;
    int b;
    int o;
    logic v;
    logic exp_ready;
    exp_a_q.delete();
    exp_b_q.delete();
    exp_e_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    start = 1'b1;
    n_samples = CNT_W'(n);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    model_acc = 0;
    cyc = 0;
    while ((model_acc < n || cyc < min_cycles) && cyc < 4000) begin
      exp_ready = (model_acc < n);
      check({tag, "_in_ready"}, 64'(in_ready), 64'(exp_ready));
      // a sample accepted at the edge after cycle c must be counted by cycle c+3
      // and cannot be counted before cycle c+1
      lo = 0;
      hi = 0;
      foreach (acc_cyc_q[i]) begin
        if (acc_cyc_q[i] <= cyc - 3) lo++;
        if (acc_cyc_q[i] <= cyc - 1) hi++;
      end
      if (int'(sample_cnt) < lo || int'(sample_cnt) > hi)
        check({tag, "_latency_window"}, 64'(sample_cnt), 64'(lo));
      else
        check({tag, "_latency_window"}, 64'(sample_cnt), 64'(sample_cnt >= CNT_W'(lo) ? sample_cnt : CNT_W'(lo)));
      start = (cyc == restart_at);
      n_samples = start ? CNT_W'(2) : CNT_W'(n);
      v = ($urandom_range(1, 100) <= valid_pct);
      if (d_a.size() > 0) begin
        a = d_a[0];
        b = d_b[0];
        o = d_o[0];
      end else begin
        a = int'($urandom_range(0, 4095));
        b = int'($urandom_range(0, 4095));
        o = rand_o(a, b);
      end
      in_valid = v;
      in_a = W'(a);
      in_b = W'(b);
      in_o = (W + 1)'(o);
      if (v && exp_ready) begin
        exp_a_q.push_back(W'(a));
        exp_b_q.push_back(W'(b));
        exp_e_q.push_back((W + 1)'(abs_err(a, b, o)));
        acc_cyc_q.push_back(cyc);
        if (d_a.size() > 0) begin
          void'(d_a.pop_front());
          void'(d_b.pop_front());
          void'(d_o.pop_front());
        end
        model_acc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    wait_cyc = 0;
    while (!done && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check_stats(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},   64'(in_ready),   64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_done"},       64'(done),       64'd0);
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
    check({tag, "_err_cnt"},    64'(err_cnt),    64'd0);
    check({tag, "_sae"},        64'(sae),        64'd0);
    check({tag, "_wce"},        64'(wce),        64'd0);
    check({tag, "_wce_a"},      64'(wce_a),      64'd0);
    check({tag, "_wce_b"},      64'(wce_b),      64'd0);
    check({tag, "_state"},      64'(state_dbg),  64'(IDLE));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    start = 1'b0;
    n_samples = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_o = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // all exact, including the largest operands
    d_a = '{0, 4095, 100, 1};
    d_b = '{0, 4095, 27, 2};
    d_o = '{0, 8190, 127, 3};
    run_test("t1_exact", 4, 100, 0, -1, w);
    check("t1_err_cnt_const", 64'(err_cnt), 64'd0);

    // single erroneous sample
    d_a = '{100};
    d_b = '{27};
    d_o = '{120};
    run_test("t2_single", 1, 100, 0, -1, w);
    check("t2_sae_const", 64'(sae), 64'd7);
    check("t2_wce_a_const", 64'(wce_a), 64'd100);

    // tie on the worst error keeps the first operands
    d_a = '{1, 2, 3};
    d_b = '{1, 2, 3};
    d_o = '{7, 13, 15};
    run_test("t3_tie", 3, 100, 0, -1, w);
    check("t3_wce_a_const", 64'(wce_a), 64'd2);
    check("t3_sae_const", 64'(sae), 64'd23);

    // valid held high well past the programmed count
    run_test("t4_hold", 3, 100, 10, -1, w);

    // empty run
    run_test("t5_zero", 0, 100, 0, -1, w);
    check("t5_zero_done_latency", 64'(w <= 3), 64'd1);

    // start during a run is ignored
    run_test("t5_restart", 5, 100, 0, 2, w);
    check("t5_restart_cnt_const", 64'(sample_cnt), 64'd5);

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    n_samples = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom_range(0, 4095));
      in_b = W'($urandom_range(0, 4095));
      in_o = '0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t6_midreset");
    rst_n = 1'b1;
    run_test("t6_after", 4, 80, 0, -1, w);

    // random runs
    for (int r = 0; r < 20; r++) begin
      run_test($sformatf("rand%0d", r), int'($urandom_range(0, 12)),
               int'($urandom_range(30, 100)), 0, -1, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
